// File: rtl/noc_mem_chan_interleaver_if.sv
// Bundle of val/rdy streams between the NoC memory port and the per-channel
// memory controllers. The interleaver is the slave side; whoever drives the
// NoC request stream and the channel responses is the master side.
interface noc_mem_chan_interleaver_if #(
  parameter int NUM_CHAN = 2,
  parameter int DATA_W   = 64
);
  logic                       req_in_val;
  logic [DATA_W-1:0]          req_in_data;
  logic                       req_in_rdy;

  logic [NUM_CHAN-1:0]        req_out_val;
  logic [NUM_CHAN*DATA_W-1:0] req_out_data;
  logic [NUM_CHAN-1:0]        req_out_rdy;

  logic [NUM_CHAN-1:0]        rsp_in_val;
  logic [NUM_CHAN*DATA_W-1:0] rsp_in_data;
  logic [NUM_CHAN-1:0]        rsp_in_rdy;

  logic                       rsp_out_val;
  logic [DATA_W-1:0]          rsp_out_data;
  logic                       rsp_out_rdy;

  modport slave (
    input  req_in_val, req_in_data, output req_in_rdy,
    output req_out_val, req_out_data, input req_out_rdy,
    input  rsp_in_val, rsp_in_data, output rsp_in_rdy,
    output rsp_out_val, rsp_out_data, input rsp_out_rdy
  );

  modport master (
    output req_in_val, req_in_data, input req_in_rdy,
    input  req_out_val, req_out_data, output req_out_rdy,
    output rsp_in_val, rsp_in_data, input rsp_in_rdy,
    input  rsp_out_val, rsp_out_data, output rsp_out_rdy
  );
endinterface

// File: rtl/noc_mem_chan_interleaver.sv
// Packet-level interleaver between the NoC memory port and NUM_CHAN memory
// channels. Requests are buffered for their two header flits so the channel
// select in flit 1 is known before flit 0 leaves, then the body is passed
// straight through. Responses are merged with packet-atomic round robin and
// zero added latency.
module noc_mem_chan_interleaver #(
  parameter int NUM_CHAN = 2,
  parameter int DATA_W   = 64,
  parameter int LEN_LSB  = 22,
  parameter int LEN_W    = 8,
  parameter int SEL_LSB  = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  noc_mem_chan_interleaver_if.slave bus,
  output logic [NUM_CHAN*16-1:0] req_pkt_cnt
);

  localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  typedef enum logic [2:0] {REQ_IDLE, REQ_HDR1, REQ_FWD0, REQ_FWD1, REQ_BODY} req_state_e;
  typedef enum logic {RSP_ARB, RSP_LOCK} rsp_state_e;

  // Cyclic successor of a channel index; a single channel always maps to 0.
  function automatic logic [CW-1:0] next_chan(input logic [CW-1:0] c);
    if (NUM_CHAN == 1) return '0;
    return CW'((int'(c) + 1) % NUM_CHAN);
  endfunction

  req_state_e        req_state_q, req_state_d;
  logic [DATA_W-1:0] h0_q, h0_d, h1_q, h1_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CW-1:0]     sel_q, sel_d;
  logic [15:0]       cnt_q [NUM_CHAN];
  logic              pkt_done;
  logic              req_in_rdy_c;
  logic              req_out_act;
  logic [DATA_W-1:0] req_flit;
  logic [LEN_W-1:0]  in_len;
  logic [CW-1:0]     in_sel;

  assign in_len = bus.req_in_data[LEN_LSB +: LEN_W];
  assign in_sel = (NUM_CHAN > 1) ? bus.req_in_data[SEL_LSB +: CW] : '0;

  // Request FSM: capture both headers, replay them to the selected channel,
  // then hand the body straight through until the length runs out.
  always_comb begin
    req_state_d  = req_state_q;
    h0_d         = h0_q;
    h1_d         = h1_q;
    rem_d        = rem_q;
    sel_d        = sel_q;
    pkt_done     = 1'b0;
    req_in_rdy_c = 1'b0;
    req_out_act  = 1'b0;
    req_flit     = h0_q;
    unique case (req_state_q)
      REQ_IDLE: begin
        req_in_rdy_c = 1'b1;
        if (bus.req_in_val) begin
          h0_d  = bus.req_in_data;
          rem_d = in_len;
          if (in_len == '0) begin
            sel_d       = '0;
            req_state_d = REQ_FWD0;
          end else begin
            req_state_d = REQ_HDR1;
          end
        end
      end
      REQ_HDR1: begin
        req_in_rdy_c = 1'b1;
        if (bus.req_in_val) begin
          h1_d        = bus.req_in_data;
          sel_d       = in_sel;
          req_state_d = REQ_FWD0;
        end
      end
      REQ_FWD0: begin
        req_out_act = 1'b1;
        req_flit    = h0_q;
        if (bus.req_out_rdy[sel_q]) begin
          if (rem_q == '0) begin
            pkt_done    = 1'b1;
            req_state_d = REQ_IDLE;
          end else begin
            req_state_d = REQ_FWD1;
          end
        end
      end
      REQ_FWD1: begin
        req_out_act = 1'b1;
        req_flit    = h1_q;
        if (bus.req_out_rdy[sel_q]) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            pkt_done    = 1'b1;
            req_state_d = REQ_IDLE;
          end else begin
            req_state_d = REQ_BODY;
          end
        end
      end
      REQ_BODY: begin
        req_out_act  = bus.req_in_val;
        req_flit     = bus.req_in_data;
        req_in_rdy_c = bus.req_out_rdy[sel_q];
        if (bus.req_in_val && bus.req_out_rdy[sel_q]) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            pkt_done    = 1'b1;
            req_state_d = REQ_IDLE;
          end
        end
      end
      default: req_state_d = REQ_IDLE;
    endcase
  end

  // Request state and header registers; reset discards any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_state_q <= REQ_IDLE;
      h0_q        <= '0;
      h1_q        <= '0;
      rem_q       <= '0;
      sel_q       <= '0;
    end else begin
      req_state_q <= req_state_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
    end
  end

  // Per-channel completed-packet counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_CHAN; j++) cnt_q[j] <= '0;
    end else if (pkt_done) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_cnt
    assign req_pkt_cnt[g*16 +: 16] = cnt_q[g];
  end

  // Only the selected channel sees val; data is broadcast since idle lanes ignore it.
  always_comb begin
    bus.req_out_val = '0;
    for (int j = 0; j < NUM_CHAN; j++) begin
      if (req_out_act && rst_n && (sel_q == CW'(j))) bus.req_out_val[j] = 1'b1;
    end
  end

  assign bus.req_out_data = {NUM_CHAN{req_flit}};
  assign bus.req_in_rdy   = req_in_rdy_c & rst_n;

  rsp_state_e        rsp_state_q, rsp_state_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     lock_q, lock_d;
  logic [LEN_W-1:0]  rcnt_q, rcnt_d;
  logic [CW-1:0]     grant;
  logic              any_val;
  int unsigned       scan_idx;
  logic [CW-1:0]     src;
  logic [DATA_W-1:0] rsp_flit;
  logic              rsp_val_c;
  logic              rsp_xfer;
  logic [LEN_W-1:0]  rsp_len;
  logic [NUM_CHAN-1:0] rsp_in_rdy_c;

  // Round-robin pick: first valid channel scanning cyclically from rr.
  always_comb begin
    grant    = '0;
    any_val  = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      scan_idx = (int'(rr_q) + k) % NUM_CHAN;
      if (!any_val && bus.rsp_in_val[scan_idx]) begin
        any_val = 1'b1;
        grant   = CW'(scan_idx);
      end
    end
  end

  assign src       = (rsp_state_q == RSP_LOCK) ? lock_q : grant;
  assign rsp_flit  = bus.rsp_in_data[src*DATA_W +: DATA_W];
  assign rsp_val_c = (rsp_state_q == RSP_LOCK) ? bus.rsp_in_val[src] : any_val;
  assign rsp_xfer  = rsp_val_c && bus.rsp_out_rdy;
  assign rsp_len   = rsp_flit[LEN_LSB +: LEN_W];

  // Ready goes back only to the channel currently granted or locked.
  always_comb begin
    rsp_in_rdy_c = '0;
    if (rst_n && ((rsp_state_q == RSP_LOCK) || any_val)) rsp_in_rdy_c[src] = bus.rsp_out_rdy;
  end

  assign bus.rsp_in_rdy   = rsp_in_rdy_c;
  assign bus.rsp_out_val  = rsp_val_c & rst_n;
  assign bus.rsp_out_data = rsp_flit;

  // Response merger: hold the granted channel for the whole packet, then
  // move the round-robin pointer just past it.
  always_comb begin
    rsp_state_d = rsp_state_q;
    rr_d        = rr_q;
    lock_d      = lock_q;
    rcnt_d      = rcnt_q;
    unique case (rsp_state_q)
      RSP_ARB: begin
        if (rsp_xfer) begin
          if (rsp_len == '0) begin
            rr_d = next_chan(grant);
          end else begin
            lock_d      = grant;
            rcnt_d      = rsp_len;
            rsp_state_d = RSP_LOCK;
          end
        end
      end
      RSP_LOCK: begin
        if (rsp_xfer) begin
          rcnt_d = rcnt_q - 1'b1;
          if (rcnt_q == LEN_W'(1)) begin
            rr_d        = next_chan(lock_q);
            rsp_state_d = RSP_ARB;
          end
        end
      end
      default: rsp_state_d = RSP_ARB;
    endcase
  end

  // Response merger registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_state_q <= RSP_ARB;
      rr_q        <= '0;
      lock_q      <= '0;
      rcnt_q      <= '0;
    end else begin
      rsp_state_q <= rsp_state_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      rcnt_q      <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_noc_mem_chan_interleaver.sv
// Bench for the four-channel interleaver: directed scenarios plus a random
// traffic phase, all checked against a packet-level reference model.
module tb_noc_mem_chan_interleaver;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] req_pkt_cnt;

  always #5 clk = ~clk;

  noc_mem_chan_interleaver_if #(.NUM_CHAN(NC), .DATA_W(64)) bus ();

  noc_mem_chan_interleaver #(
    .NUM_CHAN(NC), .DATA_W(64), .LEN_LSB(22), .LEN_W(8), .SEL_LSB(22)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .req_pkt_cnt(req_pkt_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] req_src_q[$];
  logic [63:0] exp_q [NC][$];
  bit          exp_last [NC][$];
  logic [15:0] model_cnt [NC];
  logic [63:0] rsp_src_q [NC][$];
  int          model_rr, model_left, model_locked;

  int req_val_pct, req_rdy_pct, rsp_val_pct, rsp_rdy_pct;
  int stall_ch, stall_lo, stall_hi;
  int cycle;
  bit req_taken;
  bit [NC-1:0] rsp_taken;

  int          acc_cyc[$];
  int          out_cyc[$];
  int          out_ch[$];
  bit          rdy_log[$];
  logic [63:0] rsp_log[$];
  int          rsp_cyc[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input int len, input int ch);
    logic [63:0] f;
    int tgt;
    tgt = (len == 0) ? 0 : ch;
    f = {$urandom, $urandom};
    f[29:22] = len[7:0];
    req_src_q.push_back(f);
    exp_q[tgt].push_back(f);
    exp_last[tgt].push_back(len == 0);
    if (len > 0) begin
      f = {$urandom, $urandom};
      f[23:22] = ch[1:0];
      req_src_q.push_back(f);
      exp_q[tgt].push_back(f);
      exp_last[tgt].push_back(len == 1);
    end
    for (int i = 2; i <= len; i++) begin
      f = {$urandom, $urandom};
      req_src_q.push_back(f);
      exp_q[tgt].push_back(f);
      exp_last[tgt].push_back(i == len);
    end
  endtask

  task automatic send_rsp(input int ch, input int len);
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[29:22] = len[7:0];
    rsp_src_q[ch].push_back(f);
    for (int i = 1; i <= len; i++) begin
      f = {$urandom, $urandom};
      rsp_src_q[ch].push_back(f);
    end
  endtask

  task automatic clear_logs();
    cycle = 0;
    acc_cyc.delete();
    out_cyc.delete();
    out_ch.delete();
    rdy_log.delete();
    rsp_log.delete();
    rsp_cyc.delete();
  endtask

  // One clock cycle: drive inputs on the falling edge, then check outputs
  // and advance the reference model with the transfers about to happen.
  task automatic applyStimulus();
    logic [63:0] ef, hf, exp_cnt;
    bit          el, ev;
    int          es, idx, hl;
    logic [NC-1:0] exp_rdy;

    @(negedge clk);
    if (req_taken) begin
      void'(req_src_q.pop_front());
      bus.req_in_val = 1'b0;
      req_taken = 1'b0;
    end
    if (!bus.req_in_val && req_src_q.size() > 0 && $urandom_range(99) < req_val_pct) begin
      bus.req_in_val  = 1'b1;
      bus.req_in_data = req_src_q[0];
    end
    for (int j = 0; j < NC; j++) begin
      bus.req_out_rdy[j] = ($urandom_range(99) < req_rdy_pct);
      if (j == stall_ch && cycle >= stall_lo && cycle <= stall_hi) bus.req_out_rdy[j] = 1'b0;
      if (rsp_taken[j]) begin
        void'(rsp_src_q[j].pop_front());
        bus.rsp_in_val[j] = 1'b0;
        rsp_taken[j] = 1'b0;
      end
      if (!bus.rsp_in_val[j] && rsp_src_q[j].size() > 0 && $urandom_range(99) < rsp_val_pct) begin
        bus.rsp_in_val[j] = 1'b1;
        bus.rsp_in_data[j*64 +: 64] = rsp_src_q[j][0];
      end
    end
    bus.rsp_out_rdy = ($urandom_range(99) < rsp_rdy_pct);
    #2;

    exp_cnt = {model_cnt[3], model_cnt[2], model_cnt[1], model_cnt[0]};
    checkOutput("req_pkt_cnt", req_pkt_cnt, exp_cnt);
    checkOutput("req_out_onehot", 64'($countones(bus.req_out_val) <= 1), 64'd1);
    rdy_log.push_back(bus.req_in_rdy);
    if (bus.req_in_val && bus.req_in_rdy) begin
      req_taken = 1'b1;
      acc_cyc.push_back(cycle);
    end
    for (int j = 0; j < NC; j++) begin
      if (bus.req_out_val[j] && bus.req_out_rdy[j]) begin
        out_cyc.push_back(cycle);
        out_ch.push_back(j);
        if (exp_q[j].size() == 0) begin
          checkOutput("req_out_extra_flit", 64'(exp_q[j].size()), 64'd1);
        end else begin
          ef = exp_q[j].pop_front();
          el = exp_last[j].pop_front();
          checkOutput("req_out_data", bus.req_out_data[j*64 +: 64], ef);
          if (el) model_cnt[j] = model_cnt[j] + 16'd1;
        end
      end
    end

    ev = 1'b0;
    es = 0;
    if (model_left == 0) begin
      for (int k = 0; k < NC; k++) begin
        idx = (model_rr + k) % NC;
        if (!ev && bus.rsp_in_val[idx]) begin
          ev = 1'b1;
          es = idx;
        end
      end
    end else begin
      es = model_locked;
      ev = bus.rsp_in_val[es];
    end
    checkOutput("rsp_out_val", 64'(bus.rsp_out_val), 64'(ev));
    exp_rdy = '0;
    if ((ev || model_left > 0) && bus.rsp_out_rdy) exp_rdy[es] = 1'b1;
    checkOutput("rsp_in_rdy", 64'(bus.rsp_in_rdy), 64'(exp_rdy));
    if (ev) checkOutput("rsp_out_data", bus.rsp_out_data, rsp_src_q[es][0]);
    for (int j = 0; j < NC; j++) begin
      if (bus.rsp_in_val[j] && bus.rsp_in_rdy[j]) rsp_taken[j] = 1'b1;
    end
    if (bus.rsp_out_val && bus.rsp_out_rdy) begin
      rsp_log.push_back(bus.rsp_out_data);
      rsp_cyc.push_back(cycle);
    end
    if (ev && bus.rsp_out_rdy) begin
      if (model_left == 0) begin
        hf = rsp_src_q[es][0];
        hl = int'(hf[29:22]);
        if (hl == 0) begin
          model_rr = (es + 1) % NC;
        end else begin
          model_locked = es;
          model_left   = hl;
        end
      end else begin
        model_left--;
        if (model_left == 0) model_rr = (model_locked + 1) % NC;
      end
    end
    cycle++;
  endtask

  task automatic run_until_idle(input int budget);
    int n, pend;
    n = 0;
    forever begin
      pend = req_src_q.size() + model_left;
      for (int j = 0; j < NC; j++) pend += exp_q[j].size() + rsp_src_q[j].size();
      if (pend == 0) break;
      if (n >= budget) begin
        checkOutput("drain_timeout_pending", 64'(pend), 64'd0);
        break;
      end
      applyStimulus();
      n++;
    end
  endtask

  task automatic set_pct(input int p);
    req_val_pct = p;
    req_rdy_pct = p;
    rsp_val_pct = p;
    rsp_rdy_pct = p;
  endtask

  initial begin
    logic [63:0] seq[$];
    logic [63:0] h0a, h3a;

    rst_n = 1'b0;
    bus.req_in_val  = 1'b0;
    bus.req_in_data = '0;
    bus.req_out_rdy = '0;
    bus.rsp_in_val  = '0;
    bus.rsp_in_data = '0;
    bus.rsp_out_rdy = 1'b0;
    req_taken = 1'b0;
    rsp_taken = '0;
    for (int j = 0; j < NC; j++) model_cnt[j] = '0;
    model_rr = 0;
    model_left = 0;
    model_locked = 0;
    stall_ch = -1;
    stall_lo = 0;
    stall_hi = 0;
    set_pct(100);
    clear_logs();

    // Reset state
    #12;
    checkOutput("reset_req_out_val", 64'(bus.req_out_val), 64'd0);
    checkOutput("reset_rsp_out_val", 64'(bus.rsp_out_val), 64'd0);
    checkOutput("reset_pkt_cnt", req_pkt_cnt, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_req_in_rdy", 64'(bus.req_in_rdy), 64'd1);

    // Round robin from rr=0: channels 1 and 3 both present L=3
    clear_logs();
    send_rsp(1, 3);
    send_rsp(3, 3);
    seq = {rsp_src_q[1], rsp_src_q[3]};
    run_until_idle(100);
    checkOutput("rr_flit_count", 64'(rsp_log.size()), 64'd8);
    if (rsp_log.size() == 8) begin
      for (int k = 0; k < 8; k++) checkOutput("rr_order", rsp_log[k], seq[k]);
      checkOutput("rr_contiguous", 64'(rsp_cyc[7] - rsp_cyc[0]), 64'd7);
    end
    // rr must now point at 0: channel 0 wins over channel 3
    clear_logs();
    send_rsp(0, 0);
    send_rsp(3, 0);
    h0a = rsp_src_q[0][0];
    h3a = rsp_src_q[3][0];
    run_until_idle(100);
    checkOutput("rr_wrap_count", 64'(rsp_log.size()), 64'd2);
    if (rsp_log.size() == 2) begin
      checkOutput("rr_wrap_first", rsp_log[0], h0a);
      checkOutput("rr_wrap_second", rsp_log[1], h3a);
    end

    // L=2 request to channel 1
    clear_logs();
    send_req(2, 1);
    run_until_idle(100);
    checkOutput("l2_out_count", 64'(out_cyc.size()), 64'd3);
    if (out_cyc.size() == 3 && acc_cyc.size() == 3) begin
      checkOutput("l2_h0_latency", 64'(out_cyc[0]), 64'(acc_cyc[1] + 1));
      checkOutput("l2_back_to_back", 64'(out_cyc[2] - out_cyc[0]), 64'd2);
      checkOutput("l2_channel", 64'(out_ch[2]), 64'd1);
    end
    checkOutput("l2_pkt_cnt1", 64'(req_pkt_cnt[31:16]), 64'd1);

    // L=0 request lands on channel 0 one cycle after acceptance
    clear_logs();
    send_req(0, 3);
    run_until_idle(100);
    applyStimulus();
    checkOutput("l0_out_count", 64'(out_cyc.size()), 64'd1);
    if (out_cyc.size() == 1 && acc_cyc.size() == 1) begin
      checkOutput("l0_latency", 64'(out_cyc[0]), 64'(acc_cyc[0] + 1));
      checkOutput("l0_channel", 64'(out_ch[0]), 64'd0);
      checkOutput("l0_next_idle_rdy", 64'(rdy_log[out_cyc[0] + 1]), 64'd1);
    end

    // L=4 to channel 0 with a 5-cycle back-pressure stall after the first body flit
    clear_logs();
    stall_ch = 0;
    stall_lo = 5;
    stall_hi = 9;
    send_req(4, 0);
    run_until_idle(100);
    stall_ch = -1;
    checkOutput("stall_out_count", 64'(out_cyc.size()), 64'd5);
    if (rdy_log.size() > 9) begin
      for (int k = 5; k <= 9; k++) checkOutput("stall_req_in_rdy", 64'(rdy_log[k]), 64'd0);
    end

    // Concurrent request to channel 1 and response from channel 0
    clear_logs();
    send_req(2, 1);
    send_rsp(0, 3);
    run_until_idle(100);
    checkOutput("conc_req_count", 64'(out_cyc.size()), 64'd3);
    checkOutput("conc_rsp_count", 64'(rsp_cyc.size()), 64'd4);
    if (out_cyc.size() == 3 && acc_cyc.size() == 3)
      checkOutput("conc_req_span", 64'(out_cyc[2] - acc_cyc[0]), 64'd4);
    if (rsp_cyc.size() == 4) begin
      checkOutput("conc_rsp_start", 64'(rsp_cyc[0]), 64'd0);
      checkOutput("conc_rsp_span", 64'(rsp_cyc[3] - rsp_cyc[0]), 64'd3);
    end

    // Random traffic on both paths, including maximum-length packets
    set_pct(70);
    clear_logs();
    send_req(255, 2);
    send_rsp(2, 255);
    for (int p = 0; p < 40; p++) begin
      send_req(($urandom_range(3) == 0) ? 0 : int'($urandom_range(1, 10)), int'($urandom_range(NC - 1)));
      send_rsp(int'($urandom_range(NC - 1)), ($urandom_range(3) == 0) ? 0 : int'($urandom_range(1, 10)));
    end
    run_until_idle(20000);

    // Reset in the middle of a request body and a locked response
    set_pct(100);
    clear_logs();
    send_req(6, 2);
    send_rsp(1, 6);
    for (int k = 0; k < 6; k++) applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_req_out_val", 64'(bus.req_out_val), 64'd0);
    checkOutput("midreset_rsp_out_val", 64'(bus.rsp_out_val), 64'd0);
    checkOutput("midreset_rsp_in_rdy", 64'(bus.rsp_in_rdy), 64'd0);
    req_src_q.delete();
    for (int j = 0; j < NC; j++) begin
      exp_q[j].delete();
      exp_last[j].delete();
      rsp_src_q[j].delete();
      model_cnt[j] = '0;
    end
    bus.req_in_val = 1'b0;
    bus.rsp_in_val = '0;
    req_taken = 1'b0;
    rsp_taken = '0;
    model_rr = 0;
    model_left = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("after_reset_rdy", 64'(bus.req_in_rdy), 64'd1);
    checkOutput("after_reset_cnt", req_pkt_cnt, 64'd0);
    clear_logs();
    send_req(1, 2);
    run_until_idle(100);
    checkOutput("after_reset_out_count", 64'(out_cyc.size()), 64'd2);
    if (out_cyc.size() == 2) checkOutput("after_reset_channel", 64'(out_ch[1]), 64'd2);
    applyStimulus();
    checkOutput("after_reset_pkt_cnt", req_pkt_cnt, 64'h0000_0001_0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/noc_mem_chan_interleaver.md
# noc_mem_chan_interleaver

Packet-level interleaver between the chipset NoC memory port and `NUM_CHAN` independent memory-controller channels. Each channel is a NoC-to-AXI4 bridge plus its DDR4/HBM controller, all in the `mc_clk` domain. It sits after the NoC bidirectional async FIFO. Requests are steered to a channel by address bits in header flit 1. Responses from all channels are merged back onto one NoC stream with packet-atomic round-robin arbitration. This generalises the single-channel memory path to N channels.

## Interface
- `NUM_CHAN`, 2: number of memory channels; power of two, 1..8; `CW = max(1, log2(NUM_CHAN))`.
- `DATA_W`, `` `NOC_DATA_WIDTH `` (64): flit width.
- `LEN_LSB`, 22: LSB of the payload-length field in header flit 0.
- `LEN_W`, 8: width of the length field; length L = number of flits following flit 0.
- `SEL_LSB`, 22: LSB of the channel-select field `flit1[SEL_LSB +: CW]`. With NUM_CHAN=1, selection is forced to 0.
- `clk` in 1: memory-domain clock (`mc_clk`).
- `rst_n` in 1: asynchronous, active-low reset.
- `req_in_val` in 1, `req_in_data` in DATA_W, `req_in_rdy` out 1: NoC request stream from the async FIFO.
- `req_out_val` out NUM_CHAN, `req_out_data` out NUM_CHAN*DATA_W (channel i at `[i*DATA_W +: DATA_W]`), `req_out_rdy` in NUM_CHAN: per-channel request streams.
- `rsp_in_val` in NUM_CHAN, `rsp_in_data` in NUM_CHAN*DATA_W, `rsp_in_rdy` out NUM_CHAN: per-channel response streams.
- `rsp_out_val` out 1, `rsp_out_data` out DATA_W, `rsp_out_rdy` in 1: merged response stream to the async FIFO.
- `req_pkt_cnt` out NUM_CHAN*16: per-channel count of completed request packets; wraps modulo 2^16.

## Operation
- All streams use val/rdy. A flit transfers on a cycle where val and rdy are both high. Once asserted, val and data hold until the transfer.
- Request FSM, states IDLE, HDR1, FWD0, FWD1, BODY:
  - IDLE: `req_in_rdy`=1. On transfer, capture flit 0 into `h0` and L into `rem`.
    - L==0: select channel 0, go to FWD0.
    - Otherwise go to HDR1.
  - HDR1: `req_in_rdy`=1. On transfer, capture flit 1 into `h1` and `sel = flit1[SEL_LSB +: CW]`. Go to FWD0.
  - FWD0: `req_in_rdy`=0. Present `h0` on channel `sel`. On transfer:
    - L==0: increment `req_pkt_cnt[sel]`, go to IDLE.
    - Otherwise go to FWD1.
  - FWD1: `req_in_rdy`=0. Present `h1` on channel `sel`. On transfer, `rem` decrements.
    - `rem` reaches 0: increment the count, go to IDLE.
    - Otherwise go to BODY.
  - BODY: combinational pass-through. `req_out_val[sel]=req_in_val`, `req_in_rdy=req_out_rdy[sel]`, data passes straight through. Each transfer decrements `rem`; on the last flit, increment the count and go to IDLE.
- `req_out_val[j]` is 0 for every j≠sel, and for all j in IDLE/HDR1. `req_out_data` of inactive channels is don't-care.
- Response merger, states ARB and LOCK, with round-robin pointer `rr`:
  - ARB: `grant` is the first i with `rsp_in_val[i]`, scanning cyclically from `rr`. The head flit is forwarded in the same cycle: `rsp_out_val`=1, data from `grant`, `rsp_in_rdy[grant]=rsp_out_rdy`.
    - Head transfers with L==0: `rr = grant+1` (mod NUM_CHAN), stay in ARB.
    - Head transfers with L>0: lock onto `grant`, `cnt = L`, go to LOCK.
    - Head not accepted: `grant` may change next cycle only if `rsp_in_val[grant]` is low. Because val is held, the grant is effectively stable.
  - LOCK: pass-through from the locked channel. Each transfer decrements `cnt`. When `cnt` reaches 0, set `rr = locked+1` and go to ARB.
- `rsp_in_rdy[j]` is 0 for every non-granted or non-locked channel.
- Request and response paths are fully independent. They may be active in the same cycle.

## Timing
- Reset (async assert, sync-released internally by the parent):
  - States go to IDLE/ARB; `rr`, `rem`, `cnt`, `sel` are 0.
  - `req_pkt_cnt` is 0.
  - `req_in_rdy` becomes 1 on the first cycle after reset; all `req_out_val` and `rsp_out_val` are 0.
  - Any packet in flight is discarded; no partial packet is completed.
- Request latency: flit 0 appears on a channel the cycle after flit 1 is accepted. Overhead is 2 cycles per packet with L≥1, and 1 cycle for L==0.
- Response path: zero-cycle latency. There are no bubbles between packets from different channels.
- Arithmetic: `rem` and `cnt` are LEN_W bits. L=2^LEN_W−1 must be handled without overflow.
- Counter wrap: `req_pkt_cnt` at 0xFFFF increments to 0x0000.

## Test plan
- NUM_CHAN=2. Request L=2, `flit1[22]`=1, all rdy high → channel 1 receives h0, h1, d2 in order on consecutive cycles. Channel 0 `val` never rises. `req_pkt_cnt[1]`=1.
- L==0 request → channel 0 receives exactly 1 flit, 1 cycle after acceptance. Next IDLE cycle has `req_in_rdy`=1.
- L=4 to channel 0, with `req_out_rdy[0]` low for 5 cycles mid-BODY → `req_in_rdy` is low for those 5 cycles. All 5 flits arrive intact with no duplication.
- NUM_CHAN=4, `rr`=0. Channels 1 and 3 each present an L=3 response at once → channel 1's 4 flits go out contiguously, then channel 3's. `rr` ends at 0.
- Simultaneous request to channel 1 and response from channel 0 → both complete at full throughput with no interference.
- Assert `rst_n` low during BODY of a request and during LOCK of a response → all `val` outputs drop immediately. After release, a new L=1 packet routes correctly and `req_pkt_cnt` is 0.
